cbngray_ud: RTL and testbench
=============================

# cbngray_ud

Parametrised N-bit up/down Gray-code counter with optional triple-modular redundancy (TMR). It is the general successor to the fixed 4-bit, up-only Gray counters in the DMB control logic. It keeps the "offset" scheme: a registered binary count and a registered Gray output that always describe the same value on the same clock edge. It adds direction control, parallel load, cascade output and a TMR mismatch flag, and is used for FIFO pointers, L1A/BX counters and any pointer crossing clock domains.

## Interface

**Parameters**
- WIDTH, 4, counter width in bits; legal range 2..16.
- TMR, 0, 1 = triplicated binary state with majority vote; 0 = single copy.
- IOB_Q, 1, 1 = attach the syn_useioff attribute to the Q register.

**Ports**
- CLK  in  1  single clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset; all registers clear immediately on assertion.
- CE  in  1  count enable.
- UP  in  1  direction: 1 = increment, 0 = decrement; sampled only when CE=1.
- LOAD  in  1  synchronous parallel load; has priority over CE.
- DIN  in  WIDTH  binary load value.
- Q  out  WIDTH  registered Gray code of the count.
- QI  out  WIDTH  registered binary count (voted copy when TMR=1).
- TC  out  1  terminal count in the current direction.
- CEO  out  1  cascade enable: CE & TC & ~LOAD.
- TMR_ERR  out  1  registered flag: the binary copies disagreed on the previous cycle; always 0 when TMR=0.

## Operation

- Invariant, checked after every edge: Q == QI ^ (QI >> 1).
  - Q is never derived combinationally from QI.
  - Q loads gray(next_bin) on the same edge that QI loads next_bin.
- Next-state priority:
  1. LOAD=1: next_bin = DIN.
  2. else CE=1 and UP=1: next_bin = QI + 1, modulo 2^WIDTH.
  3. else CE=1 and UP=0: next_bin = QI − 1, modulo 2^WIDTH.
  4. else: hold. Q and QI are unchanged.
- Wrap-around:
  - up from all-ones gives 0.
  - down from 0 gives all-ones; Q goes from 0 to 1 followed by WIDTH−1 zeros (only the MSB changes).
  - Every CE step changes exactly one bit of Q. A LOAD may change any number of bits.
- TC is combinational from QI and UP and is not gated by CE:
  - 1 when UP=1 and QI is all-ones;
  - 1 when UP=0 and QI is 0.
- TMR=1:
  - Three binary registers A, B, C each load the same next_bin, computed from the bitwise majority vote V(A,B,C).
  - A single upset is therefore corrected on the next edge, even when CE=0 (a hold reloads V).
  - QI = V.
  - TMR_ERR is registered from (A≠B)|(B≠C). It is non-sticky and clears one cycle after the copies agree.
- Simultaneous events: LOAD wins over CE; CEO=0 during LOAD.
- Reset mid-operation: Q, QI, all copies and TMR_ERR go to 0 asynchronously. The first edge after RST_N deasserts evaluates inputs normally.

## Timing

- Reset values:
  - Q=0, QI=0, TMR_ERR=0.
  - TC=1 if UP=0, else 0.
  - CEO=CE & TC & ~LOAD.
- Latency:
  - LOAD/CE to Q and QI: 1 cycle.
  - A TMR disagreement is corrected at the next edge.
  - TMR_ERR asserts 1 cycle after the disagreement occurs.
- TC and CEO are combinational. Cascaded stages share CLK and take CEO from the previous stage as their CE.
- Q is a pure register output (candidate for IOB placement); there is no logic between the flop and the port.

## Structure

- Shared package `cb_util_pkg`:
  - function bin2gray(WIDTH-generic);
  - function vote3 (bitwise majority);
  - constant GRAY_MAX_WIDTH = 16.
- Sub-module `cbngray_core`: binary next-state logic plus one storage copy. Instantiated once (TMR=0) or three times (TMR=1).
- Top level holds the voter, the Gray output register, TC/CEO and TMR_ERR.
- TMR copies and vote nets carry syn_keep so synthesis cannot merge them.

## Test plan

- Reset, then CE=1, UP=1 for 40 cycles (WIDTH=5) -> QI goes 0..31, 0..7. Q matches bin2gray(QI) on every cycle. At QI=31, TC=1 and CEO=1; from 31 to 0, Q goes 10000 -> 00000.
- At QI=0, apply UP=0, CE=1 -> QI=31 and Q=10000 one cycle later. TC=1 while QI=0 and UP=0. Exactly one Q bit toggles on each step.
- LOAD=1, DIN=5'h15, CE=1, UP=1 in the same cycle -> QI=0x15 and Q=0x1F next cycle, CEO=0 during the load. A hold with CE=0 keeps 0x15 for 10 cycles.
- TMR=1: force copy B to 0x0A while A=C=0x03 and CE=0 -> QI stays 0x03. B is 0x03 after the next edge. TMR_ERR is 1 for exactly one cycle.
- Assert RST_N=0 asynchronously in mid-cycle at QI=0x12 -> Q, QI and TMR_ERR read 0 before the next edge. Release, then CE=1, UP=1 -> QI=1 one cycle later.
- Two WIDTH=4 stages cascaded through CEO, run 300 cycles -> the combined binary value equals the cycle count mod 256, and the high stage advances only when the low stage wraps from 15 to 0.

Source files
------------

// File: rtl/cb_util_pkg.sv
// cb_util_pkg: shared helpers for Gray-code counters.
//   GRAY_MAX_WIDTH : widest counter the helpers support
//   bin2gray       : binary to reflected Gray code; zero-extend narrower inputs, truncate the result
//   vote3          : bitwise 2-of-3 majority
package cb_util_pkg;

    localparam int GRAY_MAX_WIDTH = 16;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_WIDTH-1:0] vote3(
        input logic [GRAY_MAX_WIDTH-1:0] a,
        input logic [GRAY_MAX_WIDTH-1:0] b,
        input logic [GRAY_MAX_WIDTH-1:0] c
    );
        return (a & b) | (b & c) | (a & c);
    endfunction

endpackage

// File: rtl/cbngray_core.sv
// cbngray_core: binary next-state logic plus one registered copy of the count.
//   CLK, RST_N : clock, asynchronous active-low reset
//   ce, up     : count enable and direction (1 = up)
//   load, din  : synchronous parallel load (priority over ce)
//   cur        : current count the next state is built from (voted value under TMR)
//   nxt        : next binary count
//   bin        : this copy's registered count
module cbngray_core #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ce,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        nxt = load ? din : ce ? (up ? cur + WIDTH'(1) : cur - WIDTH'(1)) : cur;
    end

    // A hold reloads cur rather than bin, so under TMR a corrupted copy is repaired
    // on the next edge even while counting is disabled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) bin <= '0;
        else        bin <= nxt;
    end

endmodule

// File: rtl/cbngray_ud.sv
// cbngray_ud: N-bit up/down Gray counter with parallel load, cascade output and optional TMR.
//   CLK, RST_N : clock, asynchronous active-low reset
//   CE, UP     : count enable, direction (1 = increment)
//   LOAD, DIN  : synchronous binary load, wins over CE
//   Q          : registered Gray code of the count
//   QI         : registered binary count (voted under TMR)
//   TC         : terminal count in the current direction (combinational)
//   CEO        : cascade enable for the next stage
//   TMR_ERR    : registered copy-disagreement flag (0 when TMR=0)
module cbngray_ud
    import cb_util_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int TMR   = 0,
    parameter int IOB_Q = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CE,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QI,
    output logic             TC,
    output logic             CEO,
    output logic             TMR_ERR
);

    logic [WIDTH-1:0] nxt_v;
    logic [WIDTH-1:0] nxt_gray;

    if (TMR != 0) begin : g_tmr
        (* syn_keep = 1 *) logic [WIDTH-1:0] bin_a, bin_b, bin_c;
        (* syn_keep = 1 *) logic [WIDTH-1:0] v;
        logic [WIDTH-1:0] nxt_a, nxt_b, nxt_c;
        logic             err_q;

        assign v = WIDTH'(vote3(GRAY_MAX_WIDTH'(bin_a), GRAY_MAX_WIDTH'(bin_b), GRAY_MAX_WIDTH'(bin_c)));
        assign nxt_v = WIDTH'(vote3(GRAY_MAX_WIDTH'(nxt_a), GRAY_MAX_WIDTH'(nxt_b), GRAY_MAX_WIDTH'(nxt_c)));

        cbngray_core #(.WIDTH(WIDTH)) u_a (.CLK(CLK), .RST_N(RST_N), .ce(CE), .up(UP), .load(LOAD),
                                           .din(DIN), .cur(v), .nxt(nxt_a), .bin(bin_a));
        cbngray_core #(.WIDTH(WIDTH)) u_b (.CLK(CLK), .RST_N(RST_N), .ce(CE), .up(UP), .load(LOAD),
                                           .din(DIN), .cur(v), .nxt(nxt_b), .bin(bin_b));
        cbngray_core #(.WIDTH(WIDTH)) u_c (.CLK(CLK), .RST_N(RST_N), .ce(CE), .up(UP), .load(LOAD),
                                           .din(DIN), .cur(v), .nxt(nxt_c), .bin(bin_c));

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) err_q <= 1'b0;
            else        err_q <= (bin_a != bin_b) | (bin_b != bin_c);
        end

        assign QI      = v;
        assign TMR_ERR = err_q;
    end else begin : g_single
        logic [WIDTH-1:0] bin_a;

        cbngray_core #(.WIDTH(WIDTH)) u_a (.CLK(CLK), .RST_N(RST_N), .ce(CE), .up(UP), .load(LOAD),
                                           .din(DIN), .cur(bin_a), .nxt(nxt_v), .bin(bin_a));

        assign QI      = bin_a;
        assign TMR_ERR = 1'b0;
    end

    // Q is registered from the Gray of the next binary value, so Q and QI always
    // describe the same count without any logic between the Q flop and the port.
    assign nxt_gray = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(nxt_v)));

    if (IOB_Q != 0) begin : g_q_iob
        (* syn_useioff = 1 *) logic [WIDTH-1:0] q_r;
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) q_r <= '0;
            else        q_r <= nxt_gray;
        end
        assign Q = q_r;
    end else begin : g_q_fab
        logic [WIDTH-1:0] q_r;
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) q_r <= '0;
            else        q_r <= nxt_gray;
        end
        assign Q = q_r;
    end

    assign TC  = UP ? &QI : ~|QI;
    assign CEO = CE & TC & ~LOAD;

endmodule

// File: tb/tb_cbngray_ud.sv
module tb_cbngray_ud;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce, up, load;
    logic [4:0] din;
    logic [4:0] q, qi;
    logic       tc, ceo, tmr_err;

    logic       cas_en;
    logic [3:0] lo_q, lo_qi, hi_q, hi_qi;
    logic       lo_tc, lo_ceo, lo_err, hi_tc, hi_ceo, hi_err;

    int checks   = 0;
    int failures = 0;
    int cnt      = 0;

    always #5 clk = ~clk;

    cbngray_ud #(.WIDTH(5), .TMR(1), .IOB_Q(1)) dut (
        .CLK(clk), .RST_N(rst_n), .CE(ce), .UP(up), .LOAD(load), .DIN(din),
        .Q(q), .QI(qi), .TC(tc), .CEO(ceo), .TMR_ERR(tmr_err)
    );

    cbngray_ud #(.WIDTH(4), .TMR(0), .IOB_Q(0)) u_lo (
        .CLK(clk), .RST_N(rst_n), .CE(cas_en), .UP(1'b1), .LOAD(1'b0), .DIN(4'h0),
        .Q(lo_q), .QI(lo_qi), .TC(lo_tc), .CEO(lo_ceo), .TMR_ERR(lo_err)
    );

    cbngray_ud #(.WIDTH(4), .TMR(0), .IOB_Q(0)) u_hi (
        .CLK(clk), .RST_N(rst_n), .CE(lo_ceo), .UP(1'b1), .LOAD(1'b0), .DIN(4'h0),
        .Q(hi_q), .QI(hi_qi), .TC(hi_tc), .CEO(hi_ceo), .TMR_ERR(hi_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge: drive, check combinational outputs, clock, check registers.
    task automatic step(input logic c, input logic u, input logic l, input logic [4:0] d);
        logic [4:0] prev_q;
        logic       exp_tc;
        ce = c; up = u; load = l; din = d;
        #1;
        exp_tc = u ? (cnt == 31) : (cnt == 0);
        chk("tc", tc, exp_tc);
        chk("ceo", ceo, c & exp_tc & ~l);
        prev_q = q;
        @(posedge clk);
        if (l)      cnt = d;
        else if (c) cnt = (cnt + (u ? 1 : -1)) & 31;
        #1;
        chk("qi", qi, cnt);
        chk("q_gray", q, cnt ^ (cnt >> 1));
        chk("tmr_err_idle", tmr_err, 0);
        if (c && !l) chk("q_one_bit", $countones(q ^ prev_q), 1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; up = 1'b1; load = 1'b0; din = '0; cas_en = 1'b0;
        #3;
        chk("rst_q", q, 0);
        chk("rst_qi", qi, 0);
        chk("rst_err", tmr_err, 0);
        chk("rst_tc_up", tc, 0);
        up = 1'b0;
        #1;
        chk("rst_tc_down", tc, 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 5'h00);
        chk("up40_qi", qi, 8);

        step(1'b0, 1'b0, 1'b1, 5'h00);
        step(1'b1, 1'b0, 1'b0, 5'h00);
        chk("wrap_down_q", q, 5'h10);
        chk("wrap_down_qi", qi, 5'h1f);

        step(1'b1, 1'b1, 1'b1, 5'h15);
        chk("load_q", q, 5'h1f);
        for (int i = 0; i < 10; i++) step(1'b0, i[0], 1'b0, 5'($urandom));
        chk("hold_qi", qi, 5'h15);

        for (int i = 0; i < 200; i++)
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 5'($urandom));

        step(1'b0, 1'b1, 1'b1, 5'h03);
        ce = 1'b0; load = 1'b0;
        force dut.g_tmr.u_b.bin = 5'h0a;
        #1;
        release dut.g_tmr.u_b.bin;
        #1;
        chk("tmr_vote_qi", qi, 5'h03);
        chk("tmr_err_pre", tmr_err, 0);
        @(posedge clk); #1;
        chk("tmr_fix_b", dut.g_tmr.u_b.bin, 5'h03);
        chk("tmr_fix_qi", qi, 5'h03);
        chk("tmr_err_set", tmr_err, 1);
        @(posedge clk); #1;
        chk("tmr_err_clr", tmr_err, 0);
        @(negedge clk);

        step(1'b0, 1'b1, 1'b1, 5'h12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_q", q, 0);
        chk("arst_qi", qi, 0);
        chk("arst_err", tmr_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        step(1'b1, 1'b1, 1'b0, 5'h00);
        chk("post_rst_qi", qi, 1);

        cas_en = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            chk("cascade", {hi_qi, lo_qi}, n % 256);
            chk("cascade_lo_gray", lo_q, lo_qi ^ (lo_qi >> 1));
        end
        cas_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
